// File: rtl/pcm_stream_buffer_pkg.sv
// pcm_stream_buffer_pkg: shared widths, default sizes and playback FSM states
package pcm_stream_buffer_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int DEPTH_DEF   = 64;
  localparam int PREFILL_DEF = 16;
  localparam int UCNT_W      = 8;
  typedef enum logic {ST_PREFILL, ST_PLAY} state_e;
endpackage

// File: rtl/pcm_fifo.sv
// pcm_fifo: synchronous single-clock FIFO with zero-latency head read
//   clk, rst_b      : clock, synchronous active-low reset (empties FIFO)
//   push, din       : write request and data; accepted when not full or when a pop occurs
//   pop, dout       : read request and current head; ignored when empty
//   full, empty     : occupancy flags
//   count           : occupancy, 0..DEPTH
module pcm_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;
  always_comb begin
    empty   = count_q == '0;
    full    = count_q == (AW+1)'(DEPTH);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout    = mem_q[rptr_q];
    count   = count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(do_push);
      rptr_q  <= rptr_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage is left unreset so it maps onto RAM; writes are blocked during reset
  always_ff @(posedge clk) if (rst_b && do_push) mem_q[wptr_q] <= din;
endmodule

// File: rtl/pcm_stream_buffer.sv
// pcm_stream_buffer: capture/playback sample buffering between AC97 PCM strobes and a stream client
//   clock_27mhz, reset_b           : clock, synchronous active-low reset
//   ready, audio_in_data           : codec sample strobe and captured sample
//   audio_out_data                 : registered playback sample for the codec
//   cap_data/cap_valid/cap_ready   : capture stream out
//   play_data/play_valid/play_ready: playback stream in
//   cap_overflow, play_underrun    : sticky error flags
//   underrun_count, clear_flags    : saturating starve count, flag/count clear
module pcm_stream_buffer
  import pcm_stream_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PREFILL = PREFILL_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clock_27mhz,
  input  logic                reset_b,
  input  logic                ready,
  input  logic [SAMPLE_W-1:0] audio_in_data,
  output logic [SAMPLE_W-1:0] audio_out_data,
  output logic [SAMPLE_W-1:0] cap_data,
  output logic                cap_valid,
  input  logic                cap_ready,
  input  logic [SAMPLE_W-1:0] play_data,
  input  logic                play_valid,
  output logic                play_ready,
  output logic                cap_overflow,
  output logic                play_underrun,
  output logic [UCNT_W-1:0]   underrun_count,
  input  logic                clear_flags
);
  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] audio_q, audio_d, play_head;
  logic                ovf_q, ovf_d, und_q, und_d;
  logic [UCNT_W-1:0]   ucnt_q, ucnt_d;
  logic                cap_full, cap_empty, cap_pop, ovf_ev;
  logic                play_full, play_empty, play_push, play_pop, und_ev;
  logic [AW:0]         cap_count, play_count;
  pcm_fifo #(.W(SAMPLE_W), .DEPTH(DEPTH)) u_cap (
    .clk(clock_27mhz), .rst_b(reset_b), .push(ready), .din(audio_in_data),
    .pop(cap_pop), .dout(cap_data), .full(cap_full), .empty(cap_empty), .count(cap_count)
  );
  pcm_fifo #(.W(SAMPLE_W), .DEPTH(DEPTH)) u_play (
    .clk(clock_27mhz), .rst_b(reset_b), .push(play_push), .din(play_data),
    .pop(play_pop), .dout(play_head), .full(play_full), .empty(play_empty), .count(play_count)
  );
  always_comb begin
    cap_valid  = ~cap_empty;
    cap_pop    = cap_valid & cap_ready;
    ovf_ev     = ready & cap_full & ~cap_pop;
    // playback push is refused whenever full, even if the strobe pops this cycle
    play_ready = ~play_full;
    play_push  = play_valid & ~play_full;
    play_pop   = (state_q == ST_PLAY) & ready & ~play_empty;
    und_ev     = (state_q == ST_PLAY) & ready & play_empty;
    state_d    = (state_q == ST_PREFILL) ? ((play_count >= (AW+1)'(PREFILL)) ? ST_PLAY : ST_PREFILL)
                                         : (und_ev ? ST_PREFILL : ST_PLAY);
    audio_d    = ready ? (play_pop ? play_head : '0) : audio_q;
    // a set event wins over clear, so a clear coinciding with a starve leaves count at 1
    ovf_d      = ovf_ev | (ovf_q & ~clear_flags);
    und_d      = und_ev | (und_q & ~clear_flags);
    ucnt_d     = und_ev ? (clear_flags ? UCNT_W'(1) : (&ucnt_q ? ucnt_q : ucnt_q + 1'b1))
                        : (clear_flags ? '0 : ucnt_q);
  end
  always_ff @(posedge clock_27mhz) begin
    if (!reset_b) begin
      state_q <= ST_PREFILL;
      audio_q <= '0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      audio_q <= audio_d;
      ovf_q   <= ovf_d;
      und_q   <= und_d;
      ucnt_q  <= ucnt_d;
    end
  end
  assign audio_out_data = audio_q;
  assign cap_overflow   = ovf_q;
  assign play_underrun  = und_q;
  assign underrun_count = ucnt_q;
endmodule
